// File: rtl/cpu_ex_stage.sv
// Execute stage: operand muxing, single-cycle ALU, iterative MUL/DIVU unit,
// branch-target adder and registered EX/MEM outputs with hold/flush control.
module cpu_ex_stage #(
    parameter int unsigned DW    = 16,
    parameter int unsigned IMMW  = 6,
    parameter int unsigned ADDRW = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       mux_alu_in1_select,
    input  logic [1:0]       mux_alu_in2_select,
    input  logic             ext_imm_sign,
    input  logic [DW-1:0]    rf_rd1,
    input  logic [DW-1:0]    rf_rd2,
    input  logic [DW-1:0]    bypass_from_alu,
    input  logic [DW-1:0]    bypass_from_dm,
    input  logic [DW-1:0]    pc_next_value,
    input  logic [IMMW-1:0]  instr_imm,
    input  logic [ADDRW-1:0] instr_addr,
    input  logic             hold,
    input  logic             flush,
    output logic             out_valid,
    output logic [DW-1:0]    alu_out,
    output logic             alu_zero,
    output logic [DW-1:0]    pc_branch_value,
    output logic [DW-1:0]    ext_addr,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(DW);
    localparam int unsigned CW  = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [DW-1:0]     x_q, x_d;
    logic [DW-1:0]     y_q, y_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     mpcb_q, mpcb_d;
    logic [DW-1:0]     mext_q, mext_d;
    logic              vld_q, vld_d;
    logic [DW-1:0]     res_q, res_d;
    logic              zero_q, zero_d;
    logic [DW-1:0]     pcb_q, pcb_d;
    logic [DW-1:0]     ext_q, ext_d;

    logic [DW-1:0]     imm_ext_c, addr_ext_c, opa_c, opb_c, alu_c, pcb_c, mres_c;
    logic [SHW-1:0]    shamt_c;
    logic              is_multi_c, accept_c;
    logic [DW:0]       rem_sh_c, diff_c;
    logic              ge_c;

    assign busy      = (state_q != IDLE);
    assign in_ready  = !busy && !hold && !flush;
    assign accept_c  = in_valid && in_ready;
    assign is_multi_c = (alu_op == 4'd12) || (alu_op == 4'd13);

    assign out_valid       = vld_q;
    assign alu_out         = res_q;
    assign alu_zero        = zero_q;
    assign pc_branch_value = pcb_q;
    assign ext_addr        = ext_q;

    // Immediate/address extension and operand selection
    always_comb begin
        imm_ext_c  = ext_imm_sign ? {{(DW-IMMW){instr_imm[IMMW-1]}}, instr_imm}
                                  : {{(DW-IMMW){1'b0}}, instr_imm};
        addr_ext_c = {{(DW-ADDRW){1'b0}}, instr_addr};
        pcb_c      = pc_next_value + imm_ext_c;
        case (mux_alu_in1_select)
            2'd0:    opa_c = rf_rd1;
            2'd1:    opa_c = rf_rd2;
            2'd2:    opa_c = bypass_from_alu;
            default: opa_c = bypass_from_dm;
        endcase
        case (mux_alu_in2_select)
            2'd0:    opb_c = rf_rd2;
            2'd1:    opb_c = imm_ext_c;
            2'd2:    opb_c = bypass_from_alu;
            default: opb_c = bypass_from_dm;
        endcase
        shamt_c = opb_c[SHW-1:0];
    end

    // Single-cycle ALU
    always_comb begin
        alu_c = '0;
        case (alu_op)
            4'd0:    alu_c = opa_c + opb_c;
            4'd1:    alu_c = opa_c - opb_c;
            4'd2:    alu_c = opa_c & opb_c;
            4'd3:    alu_c = opa_c | opb_c;
            4'd4:    alu_c = opa_c ^ opb_c;
            4'd5:    alu_c = opa_c << shamt_c;
            4'd6:    alu_c = opa_c >> shamt_c;
            4'd7:    alu_c = $unsigned($signed(opa_c) >>> shamt_c);
            4'd8:    alu_c = {{(DW-1){1'b0}}, ($signed(opa_c) < $signed(opb_c))};
            4'd9:    alu_c = {{(DW-1){1'b0}}, (opa_c < opb_c)};
            4'd10:   alu_c = opb_c;
            default: alu_c = '0;
        endcase
    end

    // Restoring-division step; a zero divisor naturally yields an all-ones quotient
    assign rem_sh_c = {acc_q, y_q[DW-1]};
    assign diff_c   = rem_sh_c - {1'b0, x_q};
    assign ge_c     = (rem_sh_c >= {1'b0, x_q});
    assign mres_c   = is_div_q ? y_q : acc_q;

    // Next-state: multi-cycle FSM and output registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        mpcb_d   = mpcb_q;
        mext_d   = mext_q;
        vld_d    = vld_q;
        res_d    = res_q;
        zero_d   = zero_q;
        pcb_d    = pcb_q;
        ext_d    = ext_q;

        case (state_q)
            IDLE: begin
                if (accept_c && is_multi_c) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = alu_op[0];
                    x_d      = alu_op[0] ? opb_c : opa_c;
                    y_d      = alu_op[0] ? opa_c : opb_c;
                    acc_d    = '0;
                    mpcb_d   = pcb_c;
                    mext_d   = addr_ext_c;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = ge_c ? diff_c[DW-1:0] : rem_sh_c[DW-1:0];
                    y_d   = {y_q[DW-2:0], ge_c};
                end else begin
                    acc_d = y_q[0] ? (acc_q + x_q) : acc_q;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else if (hold) begin
            vld_d   = vld_q;
        end else if (state_q == DONE) begin
            vld_d  = 1'b1;
            res_d  = mres_c;
            zero_d = (mres_c == '0);
            pcb_d  = mpcb_q;
            ext_d  = mext_q;
        end else if (accept_c && !is_multi_c) begin
            vld_d  = 1'b1;
            res_d  = alu_c;
            zero_d = (alu_c == '0);
            pcb_d  = pcb_c;
            ext_d  = addr_ext_c;
        end else begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            mpcb_q   <= '0;
            mext_q   <= '0;
            vld_q    <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            pcb_q    <= '0;
            ext_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            mpcb_q   <= mpcb_d;
            mext_q   <= mext_d;
            vld_q    <= vld_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            pcb_q    <= pcb_d;
            ext_q    <= ext_d;
        end
    end

endmodule

// File: tb/tb_cpu_ex_stage.sv
// Scoreboard bench for cpu_ex_stage: expected results queued at issue,
// compared whenever a fresh result is registered.
module tb_cpu_ex_stage;

    localparam int unsigned DW    = 16;
    localparam int unsigned IMMW  = 6;
    localparam int unsigned ADDRW = 10;

    logic             clock, reset, in_valid, in_ready;
    logic [3:0]       alu_op;
    logic [1:0]       mux_alu_in1_select, mux_alu_in2_select;
    logic             ext_imm_sign;
    logic [DW-1:0]    rf_rd1, rf_rd2, bypass_from_alu, bypass_from_dm, pc_next_value;
    logic [IMMW-1:0]  instr_imm;
    logic [ADDRW-1:0] instr_addr;
    logic             hold, flush, out_valid, alu_zero, busy;
    logic [DW-1:0]    alu_out, pc_branch_value, ext_addr;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic          z;
        logic [DW-1:0] pcb;
        logic [DW-1:0] ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    cpu_ex_stage #(.DW(DW), .IMMW(IMMW), .ADDRW(ADDRW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .mux_alu_in1_select(mux_alu_in1_select),
        .mux_alu_in2_select(mux_alu_in2_select), .ext_imm_sign(ext_imm_sign),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .bypass_from_alu(bypass_from_alu),
        .bypass_from_dm(bypass_from_dm), .pc_next_value(pc_next_value),
        .instr_imm(instr_imm), .instr_addr(instr_addr), .hold(hold), .flush(flush),
        .out_valid(out_valid), .alu_out(alu_out), .alu_zero(alu_zero),
        .pc_branch_value(pc_branch_value), .ext_addr(ext_addr), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Independent reference model of the currently driven instruction
    function automatic exp_t model();
        logic [DW-1:0] a, b, imm, r;
        logic [3:0]    sh;
        exp_t          e;
        imm = ext_imm_sign ? {{(DW-IMMW){instr_imm[IMMW-1]}}, instr_imm} : {{(DW-IMMW){1'b0}}, instr_imm};
        case (mux_alu_in1_select)
            2'd0: a = rf_rd1;  2'd1: a = rf_rd2;
            2'd2: a = bypass_from_alu;  default: a = bypass_from_dm;
        endcase
        case (mux_alu_in2_select)
            2'd0: b = rf_rd2;  2'd1: b = imm;
            2'd2: b = bypass_from_alu;  default: b = bypass_from_dm;
        endcase
        sh = b[3:0];
        case (alu_op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = $unsigned($signed(a) >>> sh);
            4'd8:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd9:  r = (a < b) ? 16'd1 : 16'd0;
            4'd10: r = b;
            4'd12: r = a * b;
            4'd13: r = (b == 16'd0) ? 16'hFFFF : a / b;
            default: r = 16'd0;
        endcase
        e.alu = r;
        e.z   = (r == 16'd0);
        e.pcb = pc_next_value + imm;
        e.ext = {{(DW-ADDRW){1'b0}}, instr_addr};
        return e;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] alu, input logic z,
                                input logic [DW-1:0] pcb, input logic [DW-1:0] ext);
        exp_t e;
        e.alu = alu; e.z = z; e.pcb = pcb; e.ext = ext;
        return e;
    endfunction

    task automatic set_op(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                          input logic sgn, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                          input logic [DW-1:0] ba, input logic [DW-1:0] bd, input logic [DW-1:0] pc,
                          input logic [IMMW-1:0] imm, input logic [ADDRW-1:0] addr);
        alu_op = op; mux_alu_in1_select = s1; mux_alu_in2_select = s2; ext_imm_sign = sgn;
        rf_rd1 = rd1; rf_rd2 = rd2; bypass_from_alu = ba; bypass_from_dm = bd;
        pc_next_value = pc; instr_imm = imm; instr_addr = addr;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input bit push, input exp_t e);
        in_valid = 1'b1;
        check("in_ready_at_issue", DW'(in_ready), 16'd1);
        @(posedge clock);
        if (push) exp_q.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("busy_timeout", DW'(busy), 16'd0);
    endtask

    // Scoreboard compare on every newly loaded result
    always @(posedge clock) begin
        logic h, f, r;
        exp_t e;
        h = hold; f = flush; r = reset;
        #1;
        if (!r && !reset && !h && !f && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", DW'(exp_q.size()), 16'd1);
            end else begin
                e = exp_q.pop_front();
                check("alu_out", alu_out, e.alu);
                check("alu_zero", DW'(alu_zero), DW'(e.z));
                check("pc_branch_value", pc_branch_value, e.pcb);
                check("ext_addr", ext_addr, e.ext);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        set_op(4'd0, 2'd0, 2'd0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        #1;
        check("rst_out_valid", DW'(out_valid), 16'd0);
        check("rst_alu_out", alu_out, 16'd0);
        check("rst_alu_zero", DW'(alu_zero), 16'd0);
        check("rst_pcb", pc_branch_value, 16'd0);
        check("rst_ext_addr", ext_addr, 16'd0);
        check("rst_busy", DW'(busy), 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // ADD with sign-extended immediate and branch target
        set_op(4'd0, 2'd0, 2'd1, 1'b1, 16'h0005, 16'h0, 16'h0, 16'h0, 16'h0100, 6'h3F, 10'h2AB);
        issue(1'b1, mk(16'h0004, 1'b0, 16'h00FF, 16'h02AB));

        // SUB through both bypass paths
        set_op(4'd1, 2'd2, 2'd3, 1'b1, 16'h0, 16'h0, 16'h1234, 16'h1234, 16'h0000, 6'h20, 10'h000);
        issue(1'b1, mk(16'h0000, 1'b1, 16'hFFE0, 16'h0000));

        // Hold keeps a single-cycle result stable
        set_op(4'd2, 2'd0, 2'd0, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 16'h0040, 6'h01, 10'h011);
        issue(1'b1, mk(16'h3030, 1'b0, 16'h0041, 16'h0011));
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_out_valid", DW'(out_valid), 16'd1);
            check("hold_alu_out", alu_out, 16'h3030);
            check("hold_in_ready", DW'(in_ready), 16'd0);
        end
        hold = 1'b0;
        @(negedge clock);
        check("bubble_out_valid", DW'(out_valid), 16'd0);

        // MUL: 16 busy cycles, single-cycle result pulse
        set_op(4'd12, 2'd0, 2'd0, 1'b0, 16'h0102, 16'h0003, 16'h0, 16'h0, 16'h0200, 6'h00, 10'h155);
        issue(1'b1, mk(16'h0306, 1'b0, 16'h0200, 16'h0155));
        for (int i = 0; i < 16; i++) begin
            check("mul_busy", DW'(busy), 16'd1);
            check("mul_in_ready", DW'(in_ready), 16'd0);
            @(negedge clock);
        end
        wait_idle();
        check("mul_out_valid", DW'(out_valid), 16'd1);
        @(negedge clock);
        check("mul_out_pulse", DW'(out_valid), 16'd0);

        // DIVU by zero, held across completion
        set_op(4'd13, 2'd3, 2'd0, 1'b0, 16'h0, 16'h0000, 16'h0, 16'h0064, 16'h1000, 6'h05, 10'h3C3);
        issue(1'b1, mk(16'hFFFF, 1'b0, 16'h1005, 16'h03C3));
        hold = 1'b1;
        repeat (20) @(negedge clock);
        check("div_hold_busy", DW'(busy), 16'd1);
        check("div_hold_out_valid", DW'(out_valid), 16'd0);
        hold = 1'b0;
        @(negedge clock);
        check("div_release_busy", DW'(busy), 16'd0);
        check("div_release_valid", DW'(out_valid), 16'd1);

        // MUL squashed by flush on cycle 5
        set_op(4'd12, 2'd0, 2'd0, 1'b0, 16'h1111, 16'h0007, 16'h0, 16'h0, 16'h0, 6'h0, 10'h0);
        issue(1'b0, mk(16'h0, 1'b0, 16'h0, 16'h0));
        repeat (4) @(negedge clock);
        flush = 1'b1;
        #1;
        check("flush_in_ready", DW'(in_ready), 16'd0);
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", DW'(busy), 16'd0);
        check("flush_out_valid", DW'(out_valid), 16'd0);
        repeat (25) @(negedge clock);
        check("flush_no_result", DW'(out_valid), 16'd0);

        // Reset mid-DIVU, then an ADD with latency 1
        set_op(4'd13, 2'd0, 2'd0, 1'b0, 16'h0100, 16'h0003, 16'h0, 16'h0, 16'h0, 6'h0, 10'h0);
        issue(1'b0, mk(16'h0, 1'b0, 16'h0, 16'h0));
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", DW'(busy), 16'd0);
        check("mid_rst_out_valid", DW'(out_valid), 16'd0);
        check("mid_rst_alu_out", alu_out, 16'd0);
        check("mid_rst_pcb", pc_branch_value, 16'd0);
        check("mid_rst_ext", ext_addr, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        set_op(4'd0, 2'd0, 2'd0, 1'b0, 16'h0007, 16'h0008, 16'h0, 16'h0, 16'h0010, 6'h02, 10'h3FF);
        issue(1'b1, mk(16'h000F, 1'b0, 16'h0012, 16'h03FF));
        repeat (25) @(negedge clock);

        // Random instructions of every opcode, including multi-cycle ones
        for (int i = 0; i < 60; i++) begin
            set_op(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 6'($urandom), 10'($urandom));
            if (i % 7 == 3) rf_rd2 = 16'h0;
            e = model();
            issue(1'b1, e);
            if (alu_op == 4'd12 || alu_op == 4'd13) wait_idle();
        end
        for (int i = 0; i < 8; i++) begin
            set_op(4'($urandom_range(12, 13)), 2'd0, 2'd0, 1'b0,
                   16'($urandom), (i == 2) ? 16'h0 : 16'($urandom_range(0, 300)),
                   16'h0, 16'h0, 16'($urandom), 6'($urandom), 10'($urandom));
            e = model();
            issue(1'b1, e);
            wait_idle();
        end
        repeat (3) @(negedge clock);
        check("queue_drained", DW'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
